// File: rtl/mdio_phy_manager_if.sv
// AXI-Lite link between the PHY manager and mdio_master:
// 5-bit PHY register address, 16-bit register data.
interface axi_lite_interface;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [15:0] wdata;
    logic [1:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [15:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport Master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport Slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/mdio_phy_manager.sv
// PHY bring-up sequencer and BMSR poller; AXI-Lite master
// feeding mdio_master.
module mdio_phy_manager #(
    parameter int unsigned STARTUP_CYCLES  = 1000,
    parameter int unsigned RESET_POLL_GAP  = 1000,
    parameter int unsigned RESET_MAX_POLLS = 16,
    parameter int unsigned POLL_INTERVAL   = 100000,
    parameter logic [15:0] ANEG_CFG        = 16'h1200,
    parameter logic [15:0] LED_CFG         = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    axi_lite_interface.Master axi_lite,
    output logic              init_done,
    output logic              init_error,
    output logic              status_valid,
    output logic              link_up,
    output logic              autoneg_done
);
    localparam int unsigned MAX_A =
        (STARTUP_CYCLES > RESET_POLL_GAP) ? STARTUP_CYCLES : RESET_POLL_GAP;
    localparam int unsigned MAX_T =
        (MAX_A > POLL_INTERVAL) ? MAX_A : POLL_INTERVAL;
    localparam int CW = $clog2(MAX_T) + 1;
    localparam int PW = $clog2(RESET_MAX_POLLS + 1) + 1;

    localparam logic [CW-1:0] C_START = CW'(STARTUP_CYCLES - 1);
    localparam logic [CW-1:0] C_GAP   = CW'(RESET_POLL_GAP - 1);
    localparam logic [CW-1:0] C_POLL  = CW'(POLL_INTERVAL - 1);
    localparam logic [PW-1:0] C_MAXP  = PW'(RESET_MAX_POLLS);

    localparam logic [2:0] S_STARTUP   = 3'd0;
    localparam logic [2:0] S_WR_RESET  = 3'd1;
    localparam logic [2:0] S_RD_BMCR   = 3'd2;
    localparam logic [2:0] S_RST_GAP   = 3'd3;
    localparam logic [2:0] S_WR_ANEG   = 3'd4;
    localparam logic [2:0] S_WR_LED    = 3'd5;
    localparam logic [2:0] S_POLL_WAIT = 3'd6;
    localparam logic [2:0] S_RD_BMSR   = 3'd7;

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_polls;
    logic          r_busy;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_aw_ok;
    logic          r_w_ok;
    logic          r_bready;
    logic          r_arvalid;
    logic          r_rready;
    logic [4:0]    r_addr;
    logic [15:0]   r_wdata;
    logic          r_restart_pend;
    logic          r_init_done;
    logic          r_init_error;
    logic          r_status_valid;
    logic          r_link_up;
    logic          r_aneg_done;

    logic          w_is_wr;
    logic [4:0]    w_addr;
    logic [15:0]   w_data;
    logic [CW-1:0] w_cnt_lim;
    logic          w_cnt_end;
    logic          w_aw_acc;
    logic          w_w_acc;
    logic          w_b_fire;
    logic          w_r_fire;
    logic [PW-1:0] w_polls_n;

    always_comb begin
        w_is_wr   = 1'b0;
        w_addr    = 5'h00;
        w_data    = 16'h0000;
        w_cnt_lim = '0;
        case (r_state)
            S_STARTUP:   w_cnt_lim = C_START;
            S_WR_RESET: begin
                w_is_wr = 1'b1;
                w_data  = 16'h8000;
            end
            S_RST_GAP:   w_cnt_lim = C_GAP;
            S_WR_ANEG: begin
                w_is_wr = 1'b1;
                w_data  = ANEG_CFG;
            end
            S_WR_LED: begin
                w_is_wr = 1'b1;
                w_addr  = 5'h18;
                w_data  = LED_CFG;
            end
            S_POLL_WAIT: w_cnt_lim = C_POLL;
            S_RD_BMSR:   w_addr = 5'h01;
            default: ;
        endcase
    end

    assign w_cnt_end = (r_cnt >= w_cnt_lim);
    assign w_aw_acc  = r_aw_ok | (r_awvalid & axi_lite.awready);
    assign w_w_acc   = r_w_ok | (r_wvalid & axi_lite.wready);
    assign w_b_fire  = r_bready & axi_lite.bvalid;
    assign w_r_fire  = r_rready & axi_lite.rvalid;
    assign w_polls_n = r_polls + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_STARTUP;
            r_cnt          <= '0;
            r_polls        <= '0;
            r_busy         <= 1'b0;
            r_awvalid      <= 1'b0;
            r_wvalid       <= 1'b0;
            r_aw_ok        <= 1'b0;
            r_w_ok         <= 1'b0;
            r_bready       <= 1'b0;
            r_arvalid      <= 1'b0;
            r_rready       <= 1'b0;
            r_addr         <= 5'h00;
            r_wdata        <= 16'h0000;
            r_restart_pend <= 1'b0;
            r_init_done    <= 1'b0;
            r_init_error   <= 1'b0;
            r_status_valid <= 1'b0;
            r_link_up      <= 1'b0;
            r_aneg_done    <= 1'b0;
        end else if (r_busy) begin
            // restart is held off until the response is accepted
            if (restart) begin
                r_restart_pend <= 1'b1;
            end
            if (w_b_fire) begin
                r_bready <= 1'b0;
                r_aw_ok  <= 1'b0;
                r_w_ok   <= 1'b0;
                r_busy   <= 1'b0;
                if (axi_lite.bresp != 2'b00) begin
                    r_init_error <= 1'b1;
                end
                case (r_state)
                    S_WR_RESET: r_state <= S_RD_BMCR;
                    S_WR_ANEG:  r_state <= S_WR_LED;
                    S_WR_LED: begin
                        r_init_done <= 1'b1;
                        r_state     <= S_RD_BMSR;
                    end
                    default: ;
                endcase
            end else if (w_r_fire) begin
                r_rready <= 1'b0;
                r_busy   <= 1'b0;
                if (axi_lite.rresp != 2'b00) begin
                    r_init_error <= 1'b1;
                end
                if (r_state == S_RD_BMCR) begin
                    r_polls <= w_polls_n;
                    if (!axi_lite.rdata[15]) begin
                        r_state <= S_WR_ANEG;
                    end else if (w_polls_n < C_MAXP) begin
                        r_state <= S_RST_GAP;
                        r_cnt   <= '0;
                    end else begin
                        r_init_error <= 1'b1;
                        r_state      <= S_WR_ANEG;
                    end
                end else begin
                    if (axi_lite.rresp == 2'b00) begin
                        r_link_up      <= axi_lite.rdata[2];
                        r_aneg_done    <= axi_lite.rdata[5];
                        r_status_valid <= 1'b1;
                    end
                    r_state <= S_POLL_WAIT;
                    r_cnt   <= '0;
                end
            end else begin
                if (r_awvalid && axi_lite.awready) begin
                    r_awvalid <= 1'b0;
                    r_aw_ok   <= 1'b1;
                end
                if (r_wvalid && axi_lite.wready) begin
                    r_wvalid <= 1'b0;
                    r_w_ok   <= 1'b1;
                end
                if (w_is_wr && w_aw_acc && w_w_acc) begin
                    r_bready <= 1'b1;
                end
                if (r_arvalid && axi_lite.arready) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                end
            end
        end else if (restart || r_restart_pend) begin
            r_restart_pend <= 1'b0;
            r_state        <= S_STARTUP;
            r_cnt          <= '0;
            r_init_done    <= 1'b0;
            r_init_error   <= 1'b0;
            r_status_valid <= 1'b0;
        end else begin
            case (r_state)
                S_STARTUP, S_RST_GAP, S_POLL_WAIT: begin
                    if (w_cnt_end) begin
                        if (r_state == S_STARTUP) begin
                            r_state <= S_WR_RESET;
                            r_polls <= '0;
                        end else if (r_state == S_RST_GAP) begin
                            r_state <= S_RD_BMCR;
                        end else begin
                            r_state <= S_RD_BMSR;
                        end
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RD_BMCR, S_RD_BMSR: begin
                    r_busy    <= 1'b1;
                    r_arvalid <= 1'b1;
                    r_addr    <= w_addr;
                end
                default: begin
                    r_busy    <= 1'b1;
                    r_awvalid <= 1'b1;
                    r_wvalid  <= 1'b1;
                    r_addr    <= w_addr;
                    r_wdata   <= w_data;
                end
            endcase
        end
    end

    assign axi_lite.awaddr  = r_addr;
    assign axi_lite.awprot  = 3'b000;
    assign axi_lite.awvalid = r_awvalid;
    assign axi_lite.wdata   = r_wdata;
    assign axi_lite.wstrb   = 2'b11;
    assign axi_lite.wvalid  = r_wvalid;
    assign axi_lite.bready  = r_bready;
    assign axi_lite.araddr  = r_addr;
    assign axi_lite.arprot  = 3'b000;
    assign axi_lite.arvalid = r_arvalid;
    assign axi_lite.rready  = r_rready;

    assign init_done    = r_init_done;
    assign init_error   = r_init_error;
    assign status_valid = r_status_valid;
    assign link_up      = r_link_up;
    assign autoneg_done = r_aneg_done;
endmodule

// File: tb/tb_mdio_phy_manager.sv
// Bench for mdio_phy_manager: AXI-Lite slave model with a
// transaction scoreboard plus directed status checks.
module tb_mdio_phy_manager;
    localparam int STARTUP = 20;
    localparam int GAP     = 10;
    localparam int MAXP    = 4;
    localparam int POLL    = 50;

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [15:0] data;
    } txn_t;

    logic clk;
    logic rst;
    logic restart;
    logic init_done;
    logic init_error;
    logic status_valid;
    logic link_up;
    logic autoneg_done;

    axi_lite_interface axi ();

    mdio_phy_manager #(
        .STARTUP_CYCLES (STARTUP),
        .RESET_POLL_GAP (GAP),
        .RESET_MAX_POLLS(MAXP),
        .POLL_INTERVAL  (POLL),
        .ANEG_CFG       (16'h1200),
        .LED_CFG        (16'h0000)
    ) u_dut (
        .clk         (clk),
        .reset       (rst),
        .restart     (restart),
        .axi_lite    (axi),
        .init_done   (init_done),
        .init_error  (init_error),
        .status_valid(status_valid),
        .link_up     (link_up),
        .autoneg_done(autoneg_done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    txn_t exp_q[$];

    // stimulus-owned slave configuration
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    int          bmcr_clear_at;
    int          err_at;
    logic [15:0] bmsr_val;
    bit          poll_free;

    // slave-owned state
    int          bmcr_reads  = 0;
    int          bmsr_issued = 0;
    int          bmsr_done   = 0;
    int          bmsr_last   = 0;
    int          bmsr_prev   = 0;
    int          aw_wait, w_wait, b_wait;
    bit          aw_got, w_got, aw_seen, w_seen, b_armed, hs_ok;
    bit          ar_got, ar_seen;
    logic [4:0]  aw_first, act_awaddr, rd_addr;
    logic [15:0] w_first, act_wdata, rd_data;
    logic [1:0]  rd_resp;

    // posedge samples of handshakes
    bit          s_aw_fire, s_w_fire, s_b_fire, s_ar_fire, s_r_fire;
    logic [4:0]  s_awaddr, s_araddr;
    logic [15:0] s_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic push_w(input logic [4:0] a, input logic [15:0] d);
        txn_t t;
        t.wr = 1'b1; t.addr = a; t.data = d;
        exp_q.push_back(t);
    endtask

    task automatic push_r(input logic [4:0] a);
        txn_t t;
        t.wr = 1'b0; t.addr = a; t.data = 16'h0000;
        exp_q.push_back(t);
    endtask

    task automatic sb_check(input bit wr, input logic [4:0] a,
                            input logic [15:0] d);
        txn_t e;
        if (exp_q.size() == 0) begin
            if (!(!wr && a == 5'h01 && poll_free)) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got wr=%0d addr=%0h data=%0h, required none",
                         wr, a, d);
            end
        end else begin
            e = exp_q.pop_front();
            chk("sb_txn", {10'd0, wr, a, d}, {10'd0, e.wr, e.addr, e.data});
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        s_aw_fire = axi.awvalid && axi.awready;
        s_w_fire  = axi.wvalid && axi.wready;
        s_b_fire  = axi.bvalid && axi.bready;
        s_ar_fire = axi.arvalid && axi.arready;
        s_r_fire  = axi.rvalid && axi.rready;
        s_awaddr  = axi.awaddr;
        s_wdata   = axi.wdata;
        s_araddr  = axi.araddr;
    end

    always @(negedge clk) begin
        if (rst) begin
            axi.awready = 1'b0; axi.wready = 1'b0;
            axi.bvalid = 1'b0;  axi.bresp = 2'b00;
            axi.arready = 1'b0; axi.rvalid = 1'b0;
            axi.rdata = 16'h0;  axi.rresp = 2'b00;
            aw_got = 0; w_got = 0; aw_seen = 0; w_seen = 0;
            b_armed = 0; hs_ok = 1; ar_got = 0; ar_seen = 0;
            aw_wait = 0; w_wait = 0; b_wait = 0;
        end else begin
            if (s_aw_fire) begin
                axi.awready = 1'b0; aw_got = 1; act_awaddr = s_awaddr;
            end else if (axi.awvalid && !aw_got) begin
                if (!aw_seen) begin
                    aw_seen = 1; aw_first = axi.awaddr;
                    if (!axi.wvalid) hs_ok = 0;
                end
                if (axi.awaddr !== aw_first) hs_ok = 0;
                if (aw_wait >= aw_dly) axi.awready = 1'b1;
                else aw_wait++;
            end else if (aw_seen && !aw_got) hs_ok = 0;

            if (s_w_fire) begin
                axi.wready = 1'b0; w_got = 1; act_wdata = s_wdata;
            end else if (axi.wvalid && !w_got) begin
                if (!w_seen) begin w_seen = 1; w_first = axi.wdata; end
                if (axi.wdata !== w_first || axi.wstrb !== 2'b11) hs_ok = 0;
                if (w_wait >= w_dly) axi.wready = 1'b1;
                else w_wait++;
            end else if (w_seen && !w_got) hs_ok = 0;

            if (s_b_fire) begin
                axi.bvalid = 1'b0;
                chk("wr_handshake", {31'd0, hs_ok}, 32'd1);
                sb_check(1'b1, act_awaddr, act_wdata);
                aw_got = 0; w_got = 0; aw_seen = 0; w_seen = 0;
                b_armed = 0; hs_ok = 1; aw_wait = 0; w_wait = 0; b_wait = 0;
            end else if (aw_got && w_got) begin
                if (axi.bready) b_armed = 1;
                else if (b_armed) hs_ok = 0;
                if (!axi.bvalid) begin
                    if (b_wait >= b_dly) begin
                        axi.bvalid = 1'b1; axi.bresp = 2'b00;
                    end else b_wait++;
                end
            end

            if (s_r_fire) begin
                axi.rvalid = 1'b0; ar_got = 0; ar_seen = 0;
                if (rd_addr == 5'h01) bmsr_done++;
            end
            if (s_ar_fire) begin
                axi.arready = 1'b0; ar_got = 1; rd_addr = s_araddr;
                sb_check(1'b0, s_araddr, 16'h0000);
                rd_data = 16'h0000; rd_resp = 2'b00;
                if (s_araddr == 5'h00) begin
                    bmcr_reads++;
                    rd_data = (bmcr_clear_at != 0 && bmcr_reads >= bmcr_clear_at)
                              ? 16'h1140 : 16'h8000;
                end else if (s_araddr == 5'h01) begin
                    bmsr_issued++;
                    rd_data = bmsr_val;
                    if (bmsr_issued == err_at) rd_resp = 2'b10;
                end
            end else if (axi.arvalid && !ar_got) begin
                if (!ar_seen) begin
                    ar_seen = 1;
                    if (axi.araddr == 5'h01) begin
                        bmsr_prev = bmsr_last; bmsr_last = cyc;
                    end
                end
                axi.arready = 1'b1;
            end
            if (ar_got && !axi.rvalid) begin
                axi.rvalid = 1'b1; axi.rdata = rd_data; axi.rresp = rd_resp;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required normal end");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rcyc;
        rst = 1'b1; restart = 1'b0;
        aw_dly = 0; w_dly = 0; b_dly = 0;
        bmcr_clear_at = 2; err_at = 0; bmsr_val = 16'h0024; poll_free = 0;
        repeat (4) @(negedge clk);
        chk("rst_flags", {27'd0, init_done, init_error, status_valid,
                          link_up, autoneg_done}, 32'd0);
        chk("rst_valids", {27'd0, axi.awvalid, axi.wvalid, axi.bready,
                           axi.arvalid, axi.rready}, 32'd0);
        push_w(5'h00, 16'h8000); push_r(5'h00); push_r(5'h00);
        push_w(5'h00, 16'h1200); push_w(5'h18, 16'h0000); push_r(5'h01);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wstrb", {30'd0, axi.wstrb}, 32'd3);
        chk("rst_prot", {26'd0, axi.awprot, axi.arprot}, 32'd0);
        chk("rst_done_after", {31'd0, init_done}, 32'd0);

        // nominal bring-up
        for (int i = 0; i < 600 && !init_done; i++) @(negedge clk);
        chk("p1_init_done", {31'd0, init_done}, 32'd1);
        for (int i = 0; i < 50 && !status_valid; i++) @(negedge clk);
        chk("p1_status_valid", {31'd0, status_valid}, 32'd1);
        chk("p1_link_up", {31'd0, link_up}, 32'd1);
        chk("p1_autoneg", {31'd0, autoneg_done}, 32'd1);
        chk("p1_init_error", {31'd0, init_error}, 32'd0);
        chk("p1_bmcr_reads", bmcr_reads, 32'd2);
        chk("p1_sb_empty", exp_q.size(), 32'd0);
        poll_free = 1;

        // periodic poll, link drops
        bmsr_val = 16'h0000;
        for (int i = 0; i < 300 && bmsr_done < 2; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("p2_link_down", {31'd0, link_up}, 32'd0);
        chk("p2_autoneg_down", {31'd0, autoneg_done}, 32'd0);
        chk("p2_poll_gap", {31'd0, (bmsr_last - bmsr_prev) >= POLL}, 32'd1);

        // error response on a BMSR read
        err_at = 3; bmsr_val = 16'h0024;
        for (int i = 0; i < 300 && bmsr_done < 3; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("p3_init_error", {31'd0, init_error}, 32'd1);
        chk("p3_link_held", {31'd0, link_up}, 32'd0);
        for (int i = 0; i < 300 && bmsr_done < 4; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("p3_poll_continues", {31'd0, link_up}, 32'd1);
        chk("p3_error_sticky", {31'd0, init_error}, 32'd1);

        // restart mid-read, then backpressure + reset timeout
        aw_dly = 3; w_dly = 7; b_dly = 5; bmcr_clear_at = 0;
        base = bmcr_reads;
        for (int i = 0; i < 300 && !(axi.arvalid && axi.araddr == 5'h01); i++)
            @(negedge clk);
        chk("p4_arvalid_seen", {31'd0, axi.arvalid}, 32'd1);
        restart = 1'b1; rcyc = cyc;
        @(negedge clk);
        restart = 1'b0;
        for (int i = 0; i < 100 && bmsr_done < 5; i++) @(negedge clk);
        chk("p4_read_completed", bmsr_done, 32'd5);
        poll_free = 0;
        push_w(5'h00, 16'h8000);
        for (int k = 0; k < MAXP; k++) push_r(5'h00);
        push_w(5'h00, 16'h1200); push_w(5'h18, 16'h0000); push_r(5'h01);
        repeat (2) @(negedge clk);
        chk("p4_restart_clear", {29'd0, init_done, init_error, status_valid},
            32'd0);
        chk("p4_link_held", {31'd0, link_up}, 32'd1);
        for (int i = 0; i < 200 && !axi.awvalid; i++) @(negedge clk);
        chk("p4_startup_gap", {31'd0, (cyc - rcyc) >= STARTUP}, 32'd1);
        for (int i = 0; i < 2000 && !init_done; i++) @(negedge clk);
        chk("p4_init_done", {31'd0, init_done}, 32'd1);
        chk("p4_timeout_error", {31'd0, init_error}, 32'd1);
        chk("p4_bmcr_reads", bmcr_reads - base, 32'd4);
        for (int i = 0; i < 100 && !status_valid; i++) @(negedge clk);
        chk("p4_status_valid", {31'd0, status_valid}, 32'd1);
        chk("p4_link_up", {31'd0, link_up}, 32'd1);
        chk("p4_sb_empty", exp_q.size(), 32'd0);

        // reset during a read drops all master handshakes
        poll_free = 1;
        for (int i = 0; i < 300 && !axi.arvalid; i++) @(negedge clk);
        chk("p5_arvalid_seen", {31'd0, axi.arvalid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("p5_rst_valids", {27'd0, axi.awvalid, axi.wvalid, axi.bready,
                              axi.arvalid, axi.rready}, 32'd0);
        chk("p5_rst_flags", {27'd0, init_done, init_error, status_valid,
                             link_up, autoneg_done}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
